// File: rtl/record_if.sv
// Audio sink and SDRAM write initiator bundle for record_core.
// master = core side, slave = codec/arbiter side.
interface record_if;
  logic        rec_write;
  logic [22:0] rec_addr;
  logic [31:0] rec_writedata;
  logic        rec_sdram_finished;
  logic        rec_audio_valid;
  logic [31:0] rec_audio_data;
  logic        rec_audio_ready;

  modport master (
    output rec_write,
    output rec_addr,
    output rec_writedata,
    input  rec_sdram_finished,
    input  rec_audio_valid,
    input  rec_audio_data,
    output rec_audio_ready
  );

  modport slave (
    input  rec_write,
    input  rec_addr,
    input  rec_writedata,
    output rec_sdram_finished,
    output rec_audio_valid,
    output rec_audio_data,
    input  rec_audio_ready
  );
endinterface

// File: rtl/record_core.sv
// Records audio samples into SDRAM as a length-prefixed clip:
// length word at base, samples from base+1, via a small FIFO.
module record_core #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [22:0] MAX_WORDS  = 23'd2_097_150
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        rec_start,
  input  logic [22:0] rec_select,
  input  logic        rec_pause,
  input  logic        rec_stop,
  output logic        rec_done,
  output logic        rec_busy,
  output logic [22:0] rec_length,
  record_if.master    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_WRLEN  = 2'd3;

  logic [1:0]  state;
  logic [22:0] base;
  logic [22:0] wr_addr;
  logic [22:0] count;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] occ;

  logic        full;
  logic        empty;
  logic        ready;
  logic        push;
  logic        pop;
  logic        draining;
  logic        last_pop;
  logic        fin;
  logic [23:0] total;
  logic [23:0] total_next;

  logic        wr_req;
  logic [22:0] wr_a;
  logic [31:0] wr_d;

  assign occ   = wr_ptr - rd_ptr;
  assign full  = occ == (AW+1)'(FIFO_DEPTH);
  assign empty = occ == '0;

  // count plus buffered words bounds acceptance at MAX_WORDS
  assign total      = {1'b0, count} + 24'(occ);
  assign total_next = total + 24'(push);

  assign ready = (state == S_RECORD) && !rec_pause
              && !full && (total < {1'b0, MAX_WORDS});
  assign push  = bus.rec_audio_valid && ready;

  assign draining = ((state == S_RECORD) || (state == S_FLUSH))
                 && !empty;
  assign fin      = bus.rec_sdram_finished && wr_req;
  assign pop      = draining && fin;
  assign last_pop = pop && (occ == (AW+1)'(1));

  always_comb begin
    wr_req = 1'b0;
    wr_a   = '0;
    wr_d   = '0;
    unique case (1'b1)
      draining: begin
        wr_req = 1'b1;
        wr_a   = wr_addr;
        wr_d   = mem[rd_ptr[AW-1:0]];
      end
      (state == S_WRLEN): begin
        wr_req = 1'b1;
        wr_a   = base;
        wr_d   = {9'b0, count};
      end
      default: ;
    endcase
  end

  assign bus.rec_write       = wr_req;
  assign bus.rec_addr        = wr_a;
  assign bus.rec_writedata   = wr_d;
  assign bus.rec_audio_ready = ready;
  assign rec_busy            = state != S_IDLE;

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= bus.rec_audio_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      base       <= '0;
      wr_addr    <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rec_done   <= 1'b0;
      rec_length <= '0;
    end else begin
      rec_done <= 1'b0;
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        wr_addr <= wr_addr + 23'd1;
        count   <= count + 23'd1;
      end
      unique case (state)
        S_IDLE: begin
          if (rec_start) begin
            base    <= rec_select;
            wr_addr <= rec_select + 23'd1;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            state   <= S_RECORD;
          end
        end
        S_RECORD: begin
          if (rec_stop || total_next >= {1'b0, MAX_WORDS})
            state <= S_FLUSH;
        end
        S_FLUSH: begin
          // leave as soon as the final data write completes
          if (empty || last_pop)
            state <= S_WRLEN;
        end
        S_WRLEN: begin
          if (fin) begin
            rec_length <= count;
            rec_done   <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_record_core.sv
// Scoreboard bench for record_core: expected SDRAM writes are
// queued on each audio handshake and matched on each finished.
module tb_record_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        rec_start;
  logic [22:0] rec_select;
  logic        rec_pause;
  logic        rec_stop;
  logic        rec_done;
  logic        rec_busy;
  logic [22:0] rec_length;

  record_if bus ();

  record_core #(
    .FIFO_DEPTH (4),
    .MAX_WORDS  (23'd8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .rec_start  (rec_start),
    .rec_select (rec_select),
    .rec_pause  (rec_pause),
    .rec_stop   (rec_stop),
    .rec_done   (rec_done),
    .rec_busy   (rec_busy),
    .rec_length (rec_length),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SDRAM model: finished after lat wait cycles
  int lat = 0;
  int wcnt = 0;
  assign bus.rec_sdram_finished =
    bus.rec_write && (wcnt >= lat);

  always @(posedge clk) begin
    if (!bus.rec_write || bus.rec_sdram_finished)
      wcnt <= 0;
    else
      wcnt <= wcnt + 1;
  end

  // audio source
  logic [31:0] tx_q [$];
  logic        hs = 1'b0;

  always @(posedge clk) begin
    #1;
    if (hs && tx_q.size() > 0)
      void'(tx_q.pop_front());
    bus.rec_audio_valid = tx_q.size() > 0;
    bus.rec_audio_data  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
  end

  // scoreboard
  logic [54:0] exp_q [$];
  logic [22:0] exp_base;
  logic [22:0] exp_addr;
  int          exp_cnt;
  int          acc;
  int          wr_obs = 0;
  int          wr_all = 0;
  int          len_cnt = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    logic [54:0] e;
    hs = bus.rec_audio_valid && bus.rec_audio_ready;
    if (!rst) begin
      if (hs) begin
        exp_q.push_back({exp_addr, bus.rec_audio_data});
        exp_addr = exp_addr + 23'd1;
        exp_cnt++;
        acc++;
      end
      if (bus.rec_write && bus.rec_sdram_finished) begin
        wr_all++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.rec_addr, e[54:32]);
          chk("wr_data", bus.rec_writedata, e[31:0]);
          wr_obs++;
        end else begin
          chk("len_addr", bus.rec_addr, exp_base);
          chk("len_data", bus.rec_writedata, exp_cnt);
          len_cnt++;
        end
      end
      if (rec_done)
        done_cnt++;
    end
  end

  task automatic set_clip(input logic [22:0] sel);
    exp_base = sel;
    exp_addr = sel + 23'd1;
    exp_cnt  = 0;
    acc      = 0;
  endtask

  task automatic do_start(input logic [22:0] sel);
    @(posedge clk); #1;
    set_clip(sel);
    rec_select = sel;
    rec_start  = 1'b1;
    @(posedge clk); #1;
    rec_start  = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge clk); #1;
    rec_stop = 1'b1;
    @(posedge clk); #1;
    rec_stop = 1'b0;
  endtask

  task automatic send(input int n, input logic [31:0] d0);
    for (int i = 0; i < n; i++)
      tx_q.push_back(d0 + 32'(i));
  endtask

  task automatic wait_tx(input int budget);
    int c = 0;
    while (tx_q.size() > 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk("tx_drain", tx_q.size(), 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int l0 = len_cnt;
    int c  = 0;
    while (done_cnt == d0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    chk(tag, done_cnt - d0, 1);
    chk("len_writes", len_cnt - l0, 1);
    chk("rec_length", rec_length, exp_cnt);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_write"}, bus.rec_write, 0);
    chk({tag, "_addr"}, bus.rec_addr, 0);
    chk({tag, "_wdata"}, bus.rec_writedata, 0);
    chk({tag, "_ready"}, bus.rec_audio_ready, 0);
    chk({tag, "_done"}, rec_done, 0);
    chk({tag, "_busy"}, rec_busy, 0);
    chk({tag, "_len"}, rec_length, 0);
  endtask

  initial begin
    int viol;
    int w0;
    int c;
    rst        = 1'b1;
    rec_start  = 1'b0;
    rec_select = '0;
    rec_pause  = 1'b0;
    rec_stop   = 1'b0;
    set_clip(23'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // basic clip
    lat = 0;
    do_start(23'h100);
    @(negedge clk);
    chk("basic_busy", rec_busy, 1);
    send(5, 32'hA0);
    wait_tx(50);
    do_stop();
    wait_done("basic_done", 50);
    chk("basic_len", rec_length, 5);
    chk("basic_acc", acc, 5);

    // SDRAM stall with valid held high
    lat = 10;
    do_start(23'h200);
    send(6, 32'hB0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("stall_acc", acc, 4);
    chk("stall_ready", bus.rec_audio_ready, 0);
    wait_tx(200);
    do_stop();
    wait_done("stall_done", 400);
    chk("stall_len", rec_length, 6);

    // pause
    lat = 0;
    do_start(23'h300);
    send(3, 32'hC0);
    wait_tx(50);
    @(posedge clk); #1;
    rec_pause = 1'b1;
    send(2, 32'hC3);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rec_audio_ready) viol++;
    end
    chk("pause_ready", viol, 0);
    chk("pause_acc", acc, 3);
    @(posedge clk); #1;
    rec_pause = 1'b0;
    wait_tx(50);
    do_stop();
    wait_done("pause_done", 50);
    chk("pause_len", rec_length, 5);

    // stop with words buffered behind a stalled write
    lat = 10;
    do_start(23'h400);
    send(3, 32'hD0);
    wait_tx(50);
    chk("stop_buffered", exp_q.size(), 3);
    do_stop();
    wait_done("stopstall_done", 300);
    chk("stopstall_len", rec_length, 3);

    // limit: auto-stop at MAX_WORDS=8 without rec_stop
    lat = 0;
    do_start(23'h500);
    send(10, 32'hE0);
    wait_done("limit_done", 200);
    chk("limit_acc", acc, 8);
    chk("limit_len", rec_length, 8);
    tx_q.delete();
    repeat (2) @(posedge clk);

    // zero-length clip: done at N+4
    lat = 0;
    @(posedge clk); #1;
    set_clip(23'h600);
    rec_select = 23'h600;
    rec_start  = 1'b1;
    @(posedge clk); #1;
    rec_start = 1'b0;
    rec_stop  = 1'b1;
    @(posedge clk); #1;
    rec_stop = 1'b0;
    @(negedge clk);
    chk("zero_flush_ready", bus.rec_audio_ready, 0);
    chk("zero_flush_busy", rec_busy, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("zero_done_t", rec_done, 1);
    chk("zero_len", rec_length, 0);
    chk("zero_busy", rec_busy, 0);

    // reset mid-record
    lat = 3;
    do_start(23'h700);
    send(4, 32'hF0);
    w0 = wr_obs;
    c  = 0;
    while (wr_obs - w0 < 2 && c < 100) begin
      @(posedge clk);
      c++;
    end
    chk("rst_two_writes", wr_obs - w0, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tx_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk_idle("midrst");
    w0 = wr_all;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_nowrite", wr_all - w0, 0);

    // normal clip after reset
    lat = 1;
    do_start(23'h7FFFFE);
    send(3, 32'h1234_0000);
    wait_tx(50);
    do_stop();
    wait_done("post_rst_done", 100);
    chk("post_rst_len", rec_length, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/record_core.md
# record_core

Captures audio sample words arriving from the audio codec interface and stores them in SDRAM as a length-prefixed clip, the same layout the playback core reads back. The length word sits at the base address and samples follow contiguously from base+1. The block sits between the top-level controller, the audio input path (valid/ready sink), and the SDRAM arbiter (write/finished initiator). A small FIFO absorbs SDRAM write latency so the audio side sees backpressure only under sustained stall.

## Interface
- FIFO_DEPTH, 4, sample buffer depth; power of two, ≥2
- MAX_WORDS, 23'd2_097_150, maximum sample words per clip; recording auto-stops at this count

- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- rec_start  in  1  begin recording; sampled only in IDLE
- rec_select  in  23  clip base address; latched on accepted start
- rec_pause  in  1  level; while high no samples are accepted
- rec_stop  in  1  end recording; pulse or level
- rec_done  out  1  one-cycle pulse when the length word has been written
- rec_busy  out  1  high in any state other than IDLE
- rec_length  out  23  sample count of the last completed clip
- rec_write  out  1  SDRAM write request
- rec_addr  out  23  SDRAM word address
- rec_writedata  out  32  SDRAM write data
- rec_sdram_finished  in  1  write of the current request is complete (same-cycle)
- rec_audio_valid  in  1  sample present
- rec_audio_data  in  32  sample word
- rec_audio_ready  out  1  block accepts the sample this cycle

## Operation
- States: IDLE, RECORD, FLUSH, WRITE_LENGTH.
- IDLE: on rec_start, latch base=rec_select, set wr_addr=base+1 and count=0, empty the FIFO, and go to RECORD. rec_stop in IDLE is ignored.
- RECORD:
  - rec_audio_ready = !rec_pause && !full && (count + occupancy < MAX_WORDS).
  - A sample is pushed when valid && ready.
  - While the FIFO is non-empty, drive rec_write=1, rec_addr=wr_addr, rec_writedata=FIFO head.
  - On rec_sdram_finished: pop, wr_addr+1, count+1.
- Stop or limit: rec_stop, or count+occupancy reaching MAX_WORDS, moves RECORD to FLUSH. A sample handshaked in the stop cycle is kept and written.
- FLUSH: ready=0; keep draining as in RECORD. When the FIFO is empty and no write is outstanding, go to WRITE_LENGTH.
- WRITE_LENGTH: rec_write=1, rec_addr=base, rec_writedata={9'b0,count}. On finished: rec_length=count, pulse rec_done, go to IDLE.
- Pause: ready=0 only. FIFO draining continues. rec_stop during pause goes to FLUSH normally.
- rec_start outside IDLE is ignored. rec_stop in FLUSH or WRITE_LENGTH is ignored.
- Count is 23-bit and never wraps, because MAX_WORDS bounds it. Address arithmetic is modulo 2^23.
- FIFO full: ready is low even if a pop occurs in the same cycle (no push-through). With the FIFO empty, push and pop cannot coincide; a pushed word becomes head on the next cycle.
- Reset mid-operation: return to IDLE and empty the FIFO. No length word is written; the partial clip is abandoned.

## Timing
- Reset values: rec_write=0, rec_addr=0, rec_writedata=0, rec_audio_ready=0, rec_done=0, rec_busy=0, rec_length=0.
- Start: rec_start at cycle N (IDLE). State is RECORD at N+1; ready may be high from N+1.
- Write handshake: rec_write, rec_addr and rec_writedata are held stable until the cycle rec_sdram_finished=1. The next request may assert in the following cycle. Minimum sample-to-SDRAM-request latency is 1 cycle after the push.
- rec_write is combinational from state and FIFO-empty. The SDRAM side must not assert finished while rec_write=0; finished with rec_write=0 is ignored.
- Stop: ready drops the cycle after rec_stop (state=FLUSH).
- Completion: the length-write request appears 1 cycle after the last data write completes. rec_done asserts in the cycle after the finished of the length write, together with state=IDLE and rec_length updated.
- Zero-length clip (start then immediate stop): RECORD → FLUSH → WRITE_LENGTH writes 0 at base. rec_done asserts at N+4 with an instant-finish SDRAM model.

## Test plan
- Basic clip: rec_select=0x100, 5 samples 0xA0..0xA4, instant finished, then stop. Required: writes 0xA0..0xA4 at 0x101..0x105, then 0x00000005 at 0x100; rec_done pulses once; rec_length=5.
- SDRAM stall: finished delayed 10 cycles per write while valid is held high. Required: ready drops after FIFO_DEPTH accepted samples; no sample lost or duplicated; addresses strictly sequential.
- Pause: 3 samples, pause for 20 cycles with valid high, resume, 2 samples, stop. Required: ready=0 throughout the pause; length word = 5; data order preserved.
- Stop during stall: stop with 3 words buffered and finished delayed. Required: all 3 written before the length word; count includes them.
- Limit: MAX_WORDS=8, valid held high. Required: auto-FLUSH at 8; length word = 8; rec_done without rec_stop.
- Reset mid-record: reset asserted after 2 of 4 writes. Required: next cycle all outputs at reset values; no length write; rec_start afterwards works normally.
